// File: rtl/fifo_arb_pkg.sv
// Shared encodings and helpers for the burst-locked FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches start+1, start+2, ... wrapping, start last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic [IW-1:0]   o_idx,
  output logic            o_found
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_start) + k) % NREQ);
      if (!o_found && i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter in front of a FIFO write port.
// Optional per-requester accept counters when FIFO_ARB_STATS_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; picks the next requester, no grant this cycle
//   ST_OWN  | owner locked; grants while FIFO not full, up to BURST words
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   fifo_full,
  output logic                   fifo_write_en,
  output logic [DW-1:0]          fifo_data_in,
  output logic [clog2(NREQ)-1:0] owner_id,
  output logic                   busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [NREQ*STAT_W-1:0] stat_cnt
`endif
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_last_owner, w_last_owner_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic          w_accept;
  logic          w_release;
  logic [IW-1:0] w_pick_start;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_found;

  // Hand-off searches from the current owner; IDLE searches from the previous one.
  assign w_pick_start = (r_state == ST_OWN) ? r_owner : r_last_owner;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req   (req),
    .i_start (w_pick_start),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    gnt = '0;
    if (r_state == ST_OWN && !fifo_full) gnt[r_owner] = 1'b1;
  end

  assign w_accept      = |(req & gnt);
  assign fifo_write_en = w_accept;
  assign busy          = (r_state == ST_OWN);
  assign owner_id      = r_owner;
  assign fifo_data_in  = busy ? req_data[int'(r_owner)*DW +: DW] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NREQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_release        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt     = ST_OWN;
          w_owner_nxt     = w_pick_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_OWN: begin
        if (!req[r_owner]) begin
          w_release = 1'b1;
        end else if (w_accept) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
          if (r_burst_cnt == BURST_LAST) w_release = 1'b1;
        end
        // Release hands straight to the next requester so there is no bubble.
        if (w_release) begin
          w_last_owner_nxt = r_owner;
          w_burst_cnt_nxt  = '0;
          if (w_pick_found) w_owner_nxt = w_pick_idx;
          else              w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [STAT_W-1:0] r_stat;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   r_stat <= '0;
      else if (stat_clr)                            r_stat <= '0;
      else if (req[g] && gnt[g] && (r_stat != '1))  r_stat <= r_stat + 1'b1;
    end
    assign stat_cnt[g*STAT_W +: STAT_W] = r_stat;
  end
`endif

endmodule
